// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM for the multi-cycle RV32 datapath.
// Optional ADDI support through EXECI is enabled with the MC_OPIMM_EN macro.
module multicycle_control #(
    parameter logic [6:0] OPC_RTYPE  = 7'b0110011,
    parameter logic [6:0] OPC_LOAD   = 7'b0000011,
    parameter logic [6:0] OPC_STORE  = 7'b0100011,
    parameter logic [6:0] OPC_BRANCH = 7'b1100011,
    parameter logic [6:0] OPC_OPIMM  = 7'b0010011
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsource,
    output logic [1:0] aluop,
    output logic       retire,
    output logic       illegal,
    output logic [3:0] state_o
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        WBMEM  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        WBALU  = 4'd7,
        BRANCH = 4'd8,
        TRAP   = 4'd9,
        EXECI  = 4'd10
    } state_t;

    state_t state_q, state_d;
    logic   illegal_q;

    // State register and sticky trap flag; trap flag sets on the edge entering TRAP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == TRAP) illegal_q <= 1'b1;
        end
    end

    // Next-state and Moore outputs; memory states gate strobes with mem_ready, reset blanks everything
    always_comb begin
        state_d     = FETCH;
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        memtoreg    = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        pcsource    = 2'b00;
        aluop       = 2'b00;
        retire      = 1'b0;
        case (state_q)
            FETCH: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                pcwrite = mem_ready;
                irwrite = mem_ready;
                state_d = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alusrcb = 2'b11;
                if (opcode == OPC_LOAD || opcode == OPC_STORE) state_d = MEMADR;
                else if (opcode == OPC_RTYPE) state_d = EXEC;
                else if (opcode == OPC_BRANCH) state_d = BRANCH;
`ifdef MC_OPIMM_EN
                else if (opcode == OPC_OPIMM) state_d = EXECI;
`else
                else if (opcode == OPC_OPIMM) state_d = TRAP;
`endif
                else state_d = TRAP;
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (opcode == OPC_LOAD) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
                state_d = mem_ready ? WBMEM : MEMRD;
            end
            WBMEM: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                retire   = 1'b1;
            end
            MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
                retire   = mem_ready;
                state_d  = mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                state_d = WBALU;
            end
            WBALU: begin
                regwrite = 1'b1;
                retire   = 1'b1;
            end
            BRANCH: begin
                alusrca     = 1'b1;
                aluop       = 2'b01;
                pcwritecond = 1'b1;
                pcsource    = 2'b01;
                retire      = 1'b1;
            end
            TRAP: state_d = TRAP;
`ifdef MC_OPIMM_EN
            EXECI: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = WBALU;
            end
`endif
            default: state_d = FETCH;
        endcase
        if (!rst_n) begin
            pcwrite     = 1'b0;
            pcwritecond = 1'b0;
            iord        = 1'b0;
            memread     = 1'b0;
            memwrite    = 1'b0;
            irwrite     = 1'b0;
            memtoreg    = 1'b0;
            regwrite    = 1'b0;
            alusrca     = 1'b0;
            alusrcb     = 2'b00;
            pcsource    = 2'b00;
            aluop       = 2'b00;
            retire      = 1'b0;
        end
    end

    assign illegal = illegal_q;
    assign state_o = state_q;
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle RV32 datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback steps.
- Drives datapath mux selects, write strobes and the 2-bit aluop consumed by the ALU-control decoder directly downstream.
- Stalls on a memory-ready handshake; traps on unsupported opcodes.

Parameters:
- OPC_RTYPE, 7'b0110011, R-type opcode
- OPC_LOAD, 7'b0000011, load opcode
- OPC_STORE, 7'b0100011, store opcode
- OPC_BRANCH, 7'b1100011, beq opcode
- OPC_OPIMM, 7'b0010011, OP-IMM opcode (used only with MC_OPIMM_EN)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  instruction register bits [6:0]; stable from DECODE until the next FETCH
- mem_ready  in  1  memory has completed the current read/write this cycle
- pcwrite  out  1  unconditional PC write
- pcwritecond  out  1  PC write if ALU zero
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- memread  out  1  memory read request
- memwrite  out  1  memory write request
- irwrite  out  1  instruction register load
- memtoreg  out  1  writeback select: 0=ALUOut, 1=MDR
- regwrite  out  1  register file write
- alusrca  out  1  ALU A select: 0=PC, 1=rs1
- alusrcb  out  2  ALU B select: 00=rs2, 01=const 4, 10=imm, 11=branch offset
- pcsource  out  2  PC mux: 00=ALU result, 01=ALUOut
- aluop  out  2  00=add, 01=sub, 10=use func7/func3
- retire  out  1  instruction completes this cycle
- illegal  out  1  sticky trap flag
- state_o  out  4  current state (debug)

Behaviour:
- State register: 4 bits, updated on rising clk. rst_n low forces state=FETCH and illegal=0 immediately.
- While rst_n is low, every control output is forced to 0, including memread and pcwrite.
- Any output not listed for a state is 0.
- All outputs are decoded from state (Moore), except pcwrite, irwrite and retire in memory states, which are also gated by mem_ready.
- State encodings and transitions:
  - 0 FETCH: memread=1, alusrca=0, alusrcb=01, aluop=00, pcsource=00. pcwrite=irwrite=mem_ready. Goes to DECODE if mem_ready, else holds.
  - 1 DECODE: alusrca=0, alusrcb=11, aluop=00 (branch target into ALUOut). Next state by opcode: LOAD or STORE -> MEMADR; RTYPE -> EXEC; BRANCH -> BRANCH; any other -> TRAP.
  - 2 MEMADR: alusrca=1, alusrcb=10, aluop=00. Goes to MEMRD if opcode=LOAD, else MEMWR.
  - 3 MEMRD: memread=1, iord=1. Goes to WBMEM on mem_ready, else holds.
  - 4 WBMEM: regwrite=1, memtoreg=1, retire=1. Goes to FETCH.
  - 5 MEMWR: memwrite=1, iord=1, retire=mem_ready. Goes to FETCH on mem_ready, else holds.
  - 6 EXEC: alusrca=1, alusrcb=00, aluop=10. Goes to WBALU.
  - 7 WBALU: regwrite=1, memtoreg=0, retire=1. Goes to FETCH.
  - 8 BRANCH: alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsource=01, retire=1. Goes to FETCH.
  - 9 TRAP: illegal set to 1 on entry and held. All strobes 0. Holds until reset.
  - 10 EXECI: exists only with MC_OPIMM_EN.
  - Unused encodings 11-15 -> next state FETCH, outputs 0.
- Latency: R-type and beq take 4/3 cycles (FETCH, DECODE, EXEC, WBALU / FETCH, DECODE, BRANCH) with mem_ready already high. Load takes 5 cycles; store takes 4. Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds one cycle.
- memread/memwrite stay asserted and iord stays constant for the whole stall.
- mem_ready is ignored in all non-memory states.
- Reset asserted mid-instruction aborts it. No regwrite, memwrite or pcwrite occurs after rst_n falls. Execution restarts at FETCH after rst_n rises.

Optional Feature:
- Macro: MC_OPIMM_EN.
- Defined: DECODE with opcode=OPC_OPIMM goes to EXECI (state 10). EXECI drives alusrca=1, alusrcb=10, aluop=00, then goes to WBALU. aluop=00 forces add, so only ADDI executes correctly.
- Undefined: OPC_OPIMM is treated as illegal and goes to TRAP; state 10 behaves as an unused encoding.

Test Plan:
- rst_n low for 2 cycles, then high with mem_ready=1: state_o=0 and memread=1 in the first cycle after release. While reset is held, all outputs are 0.
- R-type (opcode 0110011), mem_ready=1: states 0,1,6,7. aluop=10 in state 6, regwrite=1 in state 7, retire pulses once, back to 0.
- Load with mem_ready low for 3 cycles in MEMRD: states 0,1,2,3,3,3,3,4,0. memread=1 and iord=1 throughout state 3; regwrite=1 and memtoreg=1 only in state 4.
- beq: state 8 drives aluop=01, pcwritecond=1, pcsource=01. Store with mem_ready=1 in MEMWR: memwrite is a single-cycle pulse, followed by FETCH.
- Opcode 1111111 in DECODE: TRAP with illegal=1 and all strobes 0 for 10+ cycles. rst_n pulse clears illegal. With MC_OPIMM_EN, opcode 0010011 gives states 0,1,10,7 with aluop=00 and alusrcb=10 in state 10.
- rst_n dropped during MEMWR stall: memwrite falls to 0 immediately. After release, state_o=0 with no regwrite or pcwrite in between.
